// File: rtl/sq_wave_if.sv
// sq_wave_if: valid/ready load port that carries a new half-period into the square-wave generator
interface sq_wave_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] half_in;
    logic             load_valid;
    logic             load_ready;

    modport master (output half_in, output load_valid, input load_ready);
    modport slave  (input half_in, input load_valid, output load_ready);
endinterface

// File: rtl/sq_wave_gen.sv
// sq_wave_gen: programmable 50% duty square-wave source with glitch-free half-period reloads and a rising-edge counter
module sq_wave_gen #(
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 10
) (
    input  logic             clck,
    input  logic             rst_n,
    input  logic             enable,
    sq_wave_if.slave         load,
    output logic             sig_out,
    output logic [7:0]       edge_count,
    output logic             active
);
    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    state_t           state;
    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] pend_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_clamp;
    logic             xfer;
    logic             toggle;

    // A pending value blocks further loads until it has been committed at a toggle boundary
    assign load.load_ready = (state != PENDING);
    assign xfer            = load.load_valid && load.load_ready;
    // Zero would never toggle, so it is treated as the shortest legal half-period
    assign half_clamp      = (load.half_in == '0) ? CNT_W'(1) : load.half_in;
    // half_reg is never zero, so the subtraction cannot wrap
    assign toggle          = (cnt == half_reg - CNT_W'(1));

    // Single FSM: counting, toggling, edge counting and half-period hand-over all happen here
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            half_reg   <= CNT_W'(DEF_HALF);
            pend_reg   <= '0;
            cnt        <= '0;
            sig_out    <= 1'b0;
            edge_count <= '0;
            active     <= 1'b0;
        end else if (state == IDLE) begin
            cnt     <= '0;
            sig_out <= 1'b0;
            if (xfer)
                half_reg <= half_clamp;
            if (enable) begin
                state  <= RUN;
                active <= 1'b1;
            end
        end else if (!enable) begin
            state   <= IDLE;
            active  <= 1'b0;
            sig_out <= 1'b0;
            cnt     <= '0;
            if (state == PENDING)
                half_reg <= pend_reg;
            else if (xfer)
                half_reg <= half_clamp;
        end else begin
            cnt <= toggle ? '0 : cnt + CNT_W'(1);
            if (toggle) begin
                sig_out <= ~sig_out;
                if (!sig_out)
                    edge_count <= edge_count + 8'd1;
            end
            if (state == PENDING && toggle) begin
                half_reg <= pend_reg;
                state    <= RUN;
            end else if (state == RUN && xfer) begin
                pend_reg <= half_clamp;
                state    <= PENDING;
            end
        end
    end
endmodule

// File: tb/tb_sq_wave_gen.sv
// tb_sq_wave_gen: directed checks of period, reload timing, clamping, wrap, disable and async reset
module tb_sq_wave_gen;
    logic       clck = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       sig_out;
    logic [7:0] edge_count;
    logic       active;
    int         vectors = 0;
    int         miscompares = 0;

    sq_wave_if #(.CNT_W(16)) lif ();

    sq_wave_gen #(.CNT_W(16), .DEF_HALF(10)) dut (
        .clck       (clck),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (lif),
        .sig_out    (sig_out),
        .edge_count (edge_count),
        .active     (active)
    );

    always #5 clck = ~clck;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    initial begin
        lif.half_in    = '0;
        lif.load_valid = 1'b0;
        tick();
        tick();
        check("rst_sig", sig_out, 0);
        check("rst_edges", edge_count, 0);
        check("rst_active", active, 0);
        check("rst_ready", lif.load_ready, 1);
        rst_n = 1'b1;
        tick();
        check("idle_active", active, 0);

        // default half-period 10
        enable = 1'b1;
        tick();
        check("t1_active", active, 1);
        for (int k = 1; k <= 100; k++) begin
            tick();
            check("t1_sig", sig_out, (k / 10) % 2);
        end
        check("t1_edges", edge_count, 5);
        enable = 1'b0;
        tick();
        check("t1_off_sig", sig_out, 0);
        check("t1_off_active", active, 0);
        check("t1_off_edges", edge_count, 5);

        // load 3 in IDLE, then enable
        lif.half_in    = 16'd3;
        lif.load_valid = 1'b1;
        check("t2_ready_idle", lif.load_ready, 1);
        tick();
        lif.load_valid = 1'b0;
        enable = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t2_sig", sig_out, (k / 3) % 2);
            check("t2_ready", lif.load_ready, 1);
        end
        check("t2_edges", edge_count, 7);

        // half 10, load 4 while cnt==2
        enable = 1'b0;
        tick();
        lif.half_in    = 16'd10;
        lif.load_valid = 1'b1;
        enable = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        tick();
        tick();
        lif.half_in    = 16'd4;
        lif.load_valid = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        for (int k = 3; k <= 9; k++) begin
            check("t3_ready_pend", lif.load_ready, 0);
            check("t3_sig_old", sig_out, 0);
            tick();
        end
        for (int k = 10; k <= 21; k++) begin
            check("t3_sig_new", sig_out, ((k - 10) / 4) % 2 == 0 ? 1 : 0);
            check("t3_ready", lif.load_ready, 1);
            if (k < 21) tick();
        end
        check("t3_edges", edge_count, 9);

        // half_in=0 clamps to 1, run long enough to wrap edge_count
        enable = 1'b0;
        tick();
        lif.half_in    = 16'd0;
        lif.load_valid = 1'b1;
        enable = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        for (int k = 1; k <= 520; k++) begin
            tick();
            check("t4_sig", sig_out, k % 2);
            check("t4_edges", edge_count, (9 + (k + 1) / 2) % 256);
        end
        check("t5_wrapped", edge_count, 13);

        // pending load, then disable commits it
        enable = 1'b0;
        tick();
        lif.half_in    = 16'd10;
        lif.load_valid = 1'b1;
        enable = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        tick();
        tick();
        lif.half_in    = 16'd5;
        lif.load_valid = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        check("t6_ready_pend", lif.load_ready, 0);
        tick();
        enable = 1'b0;
        tick();
        check("t6_off_sig", sig_out, 0);
        check("t6_off_active", active, 0);
        check("t6_off_ready", lif.load_ready, 1);
        check("t6_off_edges", edge_count, 13);
        enable = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t6_sig_new", sig_out, (k / 5) % 2);
        end
        check("t6_edges", edge_count, 14);

        // async reset mid-RUN
        #2 rst_n = 1'b0;
        #1;
        check("t6_arst_sig", sig_out, 0);
        check("t6_arst_edges", edge_count, 0);
        check("t6_arst_active", active, 0);
        check("t6_arst_ready", lif.load_ready, 1);
        #2 rst_n = 1'b1;
        tick();
        check("t6_rerun_active", active, 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t6_def_sig", sig_out, (k / 10) % 2);
        end
        check("t6_def_edges", edge_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
